operand_forward_ctrl: RTL and testbench
=======================================

Name: operand_forward_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage datapath. Produces the 2-bit select codes that drive the two 32-bit 3:1 ALU operand muxes in EX, and the load-use stall.
- Tracks destination tags for the instructions in ID, EX, MEM and WB in an internal tag pipeline. Registers the select codes so they are stable for the whole EX cycle.

Parameters:
- REG_ADDR_WIDTH, 5, register specifier width.
- STALL_CNT_WIDTH, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs  input  REG_ADDR_WIDTH  source A register of ID instruction.
- id_rt  input  REG_ADDR_WIDTH  source B register of ID instruction.
- id_uses_rs  input  1  ID instruction reads rs.
- id_uses_rt  input  1  ID instruction reads rt.
- id_rd  input  REG_ADDR_WIDTH  destination register of ID instruction.
- id_reg_write  input  1  ID instruction writes id_rd.
- id_mem_read  input  1  ID instruction is a load.
- flush  input  1  branch/jump redirect; kill ID and EX.
- fwd_sel_a  output  2  operand A mux select for the EX instruction.
- fwd_sel_b  output  2  operand B mux select for the EX instruction.
- stall  output  1  hold PC and IF/ID this cycle (combinational).
- ex_valid  output  1  EX stage holds a real, non-bubble instruction.
- stall_count  output  STALL_CNT_WIDTH  saturating count of stall cycles.

Behaviour:
- Select encoding (shared with the operand mux):
  - 2'b00 = register file value.
  - 2'b01 = EX/MEM result.
  - 2'b10 = MEM/WB result.
  - 2'b11 is never driven.
- Tag pipeline: EX, MEM and WB entries, each holding {valid, rd, reg_write, mem_read}. All entries advance every clock.
- Reset (async, rst_n=0):
  - All entry valid bits = 0.
  - fwd_sel_a = fwd_sel_b = 2'b00.
  - stall_count = 0; ex_valid = 0; stall = 0.
- Match definition: entry X matches src s when X.valid & X.reg_write & (X.rd != 0) & (X.rd == s) & src-used.
- stall (combinational) = id_valid & !flush & EX entry is a load (mem_read) & EX matches id_rs or id_rt.
- Normal edge (no stall, no flush): ID fields load into EX with valid = id_valid.
  - Next fwd_sel_a for id_rs: if the current EX entry matches, 01; else if the current MEM entry matches, 10; else 00.
  - Next fwd_sel_b: same rule for id_rt.
  - EX/MEM has priority over MEM/WB.
- Stall edge: EX is loaded with a bubble (valid=0, sels=00). The ID instruction is re-evaluated next cycle, when the load sits in MEM, so it gets select 10.
- Flush edge: EX gets a bubble (sels=00). flush overrides stall, and stall is forced 0.
- The WB-stage writer is not forwarded. The register file is write-before-read, so ID reads already see the WB value.
- A source of r0 always yields 00.
- stall_count increments on every cycle in which stall=1 at the edge, and saturates at all-ones.
- ex_valid equals the EX entry valid bit.
- Reset mid-operation clears every entry immediately. The first post-reset instruction sees 00/00.
- Latency: selects are valid from the first clock edge that moves the instruction into EX and are held for exactly one cycle.

Decomposition:
- Shared package holds:
  - FWD_SEL_RF=2'b00, FWD_SEL_EXMEM=2'b01, FWD_SEL_MEMWB=2'b10.
  - REG_ADDR_WIDTH.
  - the tag-entry field layout.
- One natural sub-module: fwd_tag_stage. It is a single registered entry with bubble/flush insertion and is instantiated three times (EX, MEM, WB).
- Select computation and stall detection stay in the top.

Test Plan:
- ALU back-to-back: "add r3,r1,r2" then "sub r4,r3,r5" → when sub is in EX, fwd_sel_a=01, fwd_sel_b=00, stall never asserted.
- Distance-2 dependency: "add r3,..." then nop then "or r6,r7,r3" → or in EX gives fwd_sel_b=10.
- Load-use: "lw r8,0(r1)" then "add r9,r8,r8":
  - stall=1 for exactly one cycle.
  - ex_valid=0 the next cycle.
  - add in EX then has fwd_sel_a=fwd_sel_b=10.
  - stall_count increments by 1.
- Double match: "add r3" then "sub r3" then "and r10,r3,r3" → and in EX selects 01 on both operands (youngest producer wins).
- r0 and flush cases:
  - Producer writing r0 followed by a consumer of r0 → selects stay 00.
  - flush asserted during a load-use stall → stall=0, EX bubble, stall_count unchanged.
- Async reset: pull rst_n low mid-stream between edges → all outputs read 0 immediately. The next dependent pair after release forwards correctly, and stall_count saturates at 16'hFFFF under forced stalls.

Source files
------------

// File: rtl/operand_forward_ctrl_pkg.sv
// Shared definitions for the EX-stage operand forwarding controller:
// mux select codes, destination-tag entry layout and the tag match rule.
package operand_forward_ctrl_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [1:0] FWD_SEL_RF    = 2'b00;
  localparam logic [1:0] FWD_SEL_EXMEM = 2'b01;
  localparam logic [1:0] FWD_SEL_MEMWB = 2'b10;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
  } fwd_tag_t;

  // r0 is hardwired zero, so a writer of r0 never produces a forwardable value
  function automatic logic tag_match(input fwd_tag_t t,
                                     input logic [REG_ADDR_WIDTH-1:0] src,
                                     input logic used);
    return t.valid & t.reg_write & (t.rd != '0) & (t.rd == src) & used;
  endfunction

endpackage

// File: rtl/operand_forward_ctrl_tag_stage.sv
// One registered destination-tag entry; i_kill loads a bubble instead of i_tag.
module fwd_tag_stage
  import operand_forward_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_kill,
  input  fwd_tag_t i_tag,
  output fwd_tag_t o_tag
);

  fwd_tag_t r_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_tag <= '0;
    else if (i_kill) r_tag <= '0;
    else             r_tag <= i_tag;
  end

  assign o_tag = r_tag;

endmodule

// File: rtl/operand_forward_ctrl.sv
// Forwarding/hazard control: registered EX operand mux selects, load-use stall
// and a saturating stall-cycle counter, driven by an EX/MEM/WB tag pipeline.
module operand_forward_ctrl #(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid,
  input  logic [REG_ADDR_WIDTH-1:0]  id_rs,
  input  logic [REG_ADDR_WIDTH-1:0]  id_rt,
  input  logic                       id_uses_rs,
  input  logic                       id_uses_rt,
  input  logic [REG_ADDR_WIDTH-1:0]  id_rd,
  input  logic                       id_reg_write,
  input  logic                       id_mem_read,
  input  logic                       flush,
  output logic [1:0]                 fwd_sel_a,
  output logic [1:0]                 fwd_sel_b,
  output logic                       stall,
  output logic                       ex_valid,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);
  import operand_forward_ctrl_pkg::*;

  fwd_tag_t w_id_tag, w_ex_tag, w_mem_tag, w_wb_tag;
  logic     w_ex_a, w_ex_b, w_mem_a, w_mem_b;
  logic     w_stall, w_kill_ex, w_unused_wb;

  logic [1:0]                 r_sel_a, r_sel_b;
  logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

  assign w_id_tag = '{valid: id_valid, rd: id_rd,
                      reg_write: id_reg_write, mem_read: id_mem_read};

  assign w_ex_a  = tag_match(w_ex_tag,  id_rs, id_uses_rs);
  assign w_ex_b  = tag_match(w_ex_tag,  id_rt, id_uses_rt);
  assign w_mem_a = tag_match(w_mem_tag, id_rs, id_uses_rs);
  assign w_mem_b = tag_match(w_mem_tag, id_rt, id_uses_rt);

  // A load result only exists after MEM, so a dependent in ID waits one cycle
  assign w_stall   = id_valid & ~flush & w_ex_tag.mem_read & (w_ex_a | w_ex_b);
  assign w_kill_ex = w_stall | flush;

  fwd_tag_stage u_ex  (.clk, .rst_n, .i_kill(w_kill_ex), .i_tag(w_id_tag),  .o_tag(w_ex_tag));
  fwd_tag_stage u_mem (.clk, .rst_n, .i_kill(1'b0),      .i_tag(w_ex_tag),  .o_tag(w_mem_tag));
  fwd_tag_stage u_wb  (.clk, .rst_n, .i_kill(1'b0),      .i_tag(w_mem_tag), .o_tag(w_wb_tag));

  // WB is tracked but never forwarded: the register file writes before it reads
  assign w_unused_wb = ^w_wb_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_a <= FWD_SEL_RF;
      r_sel_b <= FWD_SEL_RF;
    end else if (w_kill_ex) begin
      r_sel_a <= FWD_SEL_RF;
      r_sel_b <= FWD_SEL_RF;
    end else begin
      r_sel_a <= w_ex_a ? FWD_SEL_EXMEM : (w_mem_a ? FWD_SEL_MEMWB : FWD_SEL_RF);
      r_sel_b <= w_ex_b ? FWD_SEL_EXMEM : (w_mem_b ? FWD_SEL_MEMWB : FWD_SEL_RF);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + STALL_CNT_WIDTH'(1);
  end

  assign fwd_sel_a   = r_sel_a;
  assign fwd_sel_b   = r_sel_b;
  assign stall       = w_stall;
  assign ex_valid    = w_ex_tag.valid;
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Scoreboard bench for operand_forward_ctrl; a 4-bit-counter copy shares the
// stimulus so counter saturation is reachable in a short run.
module tb_operand_forward_ctrl;

  logic       clk, rst_n;
  logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, flush;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [1:0] fwd_sel_a, fwd_sel_b, s_sel_a, s_sel_b;
  logic       stall, ex_valid, s_stall, s_ex_valid;
  logic [15:0] stall_count;
  logic [3:0]  s_stall_count;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  typedef struct {
    logic       v;
    logic [1:0] a;
    logic [1:0] b;
    string      tag;
  } exp_t;
  exp_t sb_q[$];

  operand_forward_ctrl u_dut (
    .clk, .rst_n, .id_valid, .id_rs, .id_rt, .id_uses_rs, .id_uses_rt,
    .id_rd, .id_reg_write, .id_mem_read, .flush,
    .fwd_sel_a, .fwd_sel_b, .stall, .ex_valid, .stall_count
  );

  operand_forward_ctrl #(.STALL_CNT_WIDTH(4)) u_dut_sat (
    .clk, .rst_n, .id_valid, .id_rs, .id_rt, .id_uses_rs, .id_uses_rt,
    .id_rd, .id_reg_write, .id_mem_read, .flush,
    .fwd_sel_a(s_sel_a), .fwd_sel_b(s_sel_b), .stall(s_stall),
    .ex_valid(s_ex_valid), .stall_count(s_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, act, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".cnt"}, 32'(stall_count), 32'(exp_cnt));
    chk({tag, ".cnt4"}, 32'(s_stall_count), (exp_cnt > 15) ? 32'd15 : 32'(exp_cnt));
  endtask

  // Drive one ID cycle; called at posedge+1. Checks comb stall, then the EX
  // state the instruction (or bubble) produces after the edge.
  task automatic cyc(input string tag, input logic v,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt,
                     input logic [4:0] rd, input logic rw, input logic mr,
                     input logic fl, input logic xs, input logic xv,
                     input logic [1:0] xa, input logic [1:0] xb);
    exp_t e;
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
    #1;
    chk({tag, ".stall"}, 32'(stall), 32'(xs));
    if (xs) exp_cnt++;
    sb_q.push_back('{v: xv, a: xa, b: xb, tag: tag});
    @(posedge clk); #1;
    e = sb_q.pop_front();
    chk({e.tag, ".exv"},  32'(ex_valid),  32'(e.v));
    chk({e.tag, ".sela"}, 32'(fwd_sel_a), 32'(e.a));
    chk({e.tag, ".selb"}, 32'(fwd_sel_b), 32'(e.b));
    chk_cnt(e.tag);
  endtask

  task automatic nop(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) nop("drain");
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.exv",  32'(ex_valid),  0);
    chk("rst.sela", 32'(fwd_sel_a), 0);
    chk("rst.selb", 32'(fwd_sel_b), 0);
    chk("rst.stall", 32'(stall), 0);
    chk_cnt("rst");
    rst_n = 1'b1;

    // back-to-back ALU dependency, plus an unused source that must not forward
    cyc("alu.add", 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1, 2'b00, 2'b00);
    cyc("alu.sub", 1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 1, 2'b01, 2'b00);
    cyc("alu.nouse", 1, 7, 3, 1, 0, 6, 1, 0, 0, 0, 1, 2'b00, 2'b00);
    drain();

    // distance-2 dependency
    cyc("d2.add", 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1, 2'b00, 2'b00);
    nop("d2.nop");
    cyc("d2.or",  1, 7, 3, 1, 1, 6, 1, 0, 0, 0, 1, 2'b00, 2'b10);
    drain();

    // load-use: one stall, bubble, then MEM/WB forward on both operands
    cyc("lu.lw",    1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 1, 2'b00, 2'b00);
    cyc("lu.stall", 1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    cyc("lu.add",   1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 1, 2'b10, 2'b10);
    drain();

    // two producers of r3: youngest wins
    cyc("dm.add", 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1, 2'b00, 2'b00);
    cyc("dm.sub", 1, 4, 5, 1, 1, 3, 1, 0, 0, 0, 1, 2'b00, 2'b00);
    cyc("dm.and", 1, 3, 3, 1, 1, 10, 1, 0, 0, 0, 1, 2'b01, 2'b01);
    drain();

    // writes to r0 never forward
    cyc("r0.add", 1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00);
    cyc("r0.or",  1, 0, 0, 1, 1, 5, 1, 0, 0, 0, 1, 2'b00, 2'b00);
    cyc("r0.xor", 1, 0, 0, 1, 1, 6, 1, 0, 0, 0, 1, 2'b00, 2'b00);
    drain();

    // flush over a load-use hazard: no stall, bubble, counter unchanged
    cyc("fl.lw",  1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 1, 2'b00, 2'b00);
    cyc("fl.kill", 1, 8, 8, 1, 1, 9, 1, 0, 1, 0, 0, 2'b00, 2'b00);
    cyc("fl.add",  1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 1, 2'b10, 2'b10);
    drain();

    // async reset between edges with a live producer in EX
    cyc("ar.add", 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1, 2'b00, 2'b00);
    id_valid = 1; id_rs = 3; id_rt = 3; id_uses_rs = 1; id_uses_rt = 1;
    id_rd = 4; id_reg_write = 1; id_mem_read = 0;
    #2;
    chk("ar.pre.exv", 32'(ex_valid), 1);
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("ar.exv",  32'(ex_valid),  0);
    chk("ar.sela", 32'(fwd_sel_a), 0);
    chk("ar.selb", 32'(fwd_sel_b), 0);
    chk("ar.stall", 32'(stall), 0);
    chk_cnt("ar");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("ar.add2", 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1, 2'b00, 2'b00);
    cyc("ar.sub2", 1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 1, 2'b01, 2'b00);
    drain();

    // repeated load-use stalls: 4-bit copy saturates, 16-bit copy keeps counting
    for (int i = 0; i < 20; i++) begin
      cyc("sat.lw",    1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 1, 2'b00, 2'b00);
      cyc("sat.stall", 1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 0, 2'b00, 2'b00);
      cyc("sat.add",   1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 1, 2'b10, 2'b10);
    end
    chk("sat.final16", 32'(stall_count), 20);
    chk("sat.final4",  32'(s_stall_count), 15);
    chk("sb.empty", 32'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
